fifo_write_arbiter: RTL and testbench

//   Shares the single write port of one `fifo` instance among NUM_REQ

---
 rtl/fifo_write_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_write_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: finds the first valid requester strictly after `last`,
// wrapping modulo N. Purely combinational so it can also serve a read scheduler.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    // cand[gi] is the requester with priority rank gi (rank 0 is highest).
    logic [IW-1:0] cand [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand[gi] = IW'((int'(last) + gi + 1) % N);
    end

    // Walk ranks from lowest to highest so the highest-ranked hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one fifo write port among NUM_REQ valid/ready producers with
// round-robin grants of at most BURST_LEN beats each.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   last_owner_reg, last_owner_next;
    logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic                  owner_valid;
    logic                  transfer;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .valid (req_valid),
        .last  (last_owner_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // last_owner resets to the top index so requester 0 wins the first search.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ARB;
            owner_reg      <= '0;
            last_owner_reg <= IW'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        beat_cnt_next   = beat_cnt_reg;
        req_ready       = '0;
        fifo_write_en   = 1'b0;
        fifo_write_data = '0;
        grant_valid     = 1'b0;
        grant_id        = '0;
        owner_valid     = req_valid[owner_reg];
        transfer        = 1'b0;

        case (state_reg)
            ARB: begin
                if (pick_found) begin
                    owner_next    = pick_idx;
                    beat_cnt_next = '0;
                    state_next    = OWN;
                end
            end
            OWN: begin
                grant_valid          = 1'b1;
                grant_id             = owner_reg;
                req_ready[owner_reg] = !fifo_full;
                transfer             = owner_valid && !fifo_full;
                fifo_write_en        = transfer;
                fifo_write_data      = data_arr[owner_reg];
                // A full fifo stalls the burst without consuming a beat.
                if (!owner_valid || (transfer && beat_cnt_reg == LAST_BEAT)) begin
                    state_next      = ARB;
                    last_owner_next = owner_reg;
                    beat_cnt_next   = '0;
                end else if (transfer) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            default: state_next = ARB;
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboarded bench for fifo_write_arbiter with a behavioural fifo sink.
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BL    = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_write_en;
    logic [DW-1:0]   fifo_write_data;
    logic            fifo_full = 1'b0;
    logic            grant_valid;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .fifo_full       (fifo_full),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] pq[N][$];
    logic [7:0] log_d[$];
    int         log_id[$];
    int         log_c[$];
    logic [7:0] rd_log[$];

    bit         sb_en = 1'b1;
    bit         drain = 1'b0;
    bit         rd_once = 1'b0;
    bit         rand_mode = 1'b0;
    logic [N-1:0] en = '1;
    int         cyc = 0;
    int         exp_seq[N];
    int         gen_seq[N];

    logic       s_we, s_gv;
    logic [N-1:0] s_rdy;
    logic [1:0] s_gid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every accepted fifo write must match the next expected beat.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (!$onehot0(req_ready)) begin
                failures++;
                $display("FAIL onehot_ready: got %b expected at most one bit", req_ready);
            end
            checks++;
            if (fifo_write_en && fifo_full) begin
                failures++;
                $display("FAIL write_while_full: got write_en=1 expected 0 at cycle %0d", cyc);
            end
            if (sb_en && fifo_write_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %02h expected no write", fifo_write_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (fifo_write_data !== e) begin
                        failures++;
                        $display("FAIL sb_data: got %02h expected %02h", fifo_write_data, e);
                    end
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (pq[i].size() > 0);
            req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
        end
        fifo_full = (fifo_q.size() >= DEPTH);
    endtask

    task automatic step();
        logic we, rd;
        logic [7:0] wd, v;
        logic [N-1:0] acc;
        int id;
        @(negedge clk);
        we    = fifo_write_en && reset;
        wd    = fifo_write_data;
        acc   = req_valid & req_ready & {N{reset}};
        s_we  = fifo_write_en;
        s_rdy = req_ready;
        s_gv  = grant_valid;
        s_gid = grant_id;
        if (we) begin
            log_d.push_back(wd);
            log_id.push_back(int'(grant_id));
            log_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        rd = (drain || rd_once || (rand_mode && (cyc % 20 == 0))) && (fifo_q.size() > 0);
        rd_once = 1'b0;
        if (rd) begin
            v = fifo_q.pop_front();
            rd_log.push_back(v);
            if (rand_mode) begin
                id = int'(v[7:6]);
                check("t6_order", {26'd0, v[5:0]}, 32'(exp_seq[id] % 64));
                exp_seq[id]++;
            end
        end
        if (we && fifo_q.size() < DEPTH) fifo_q.push_back(wd);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(pq[i].pop_front());
        end
        drive();
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (log_d.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(log_d.size() >= n), 32'd1);
    endtask

    task automatic wait_fifo_empty(input int budget);
        int k;
        k = 0;
        while (fifo_q.size() > 0 && k < budget) begin
            step();
            k++;
        end
        check("fifo_drained", 32'(fifo_q.size()), 32'd0);
    endtask

    task automatic clear_log();
        log_d.delete();
        log_id.delete();
        log_c.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, d, expd;
        logic [7:0] v;

        // Test 1: four continuous producers, reset values first.
        for (int i = 0; i < N; i++)
            for (int n = 0; n < 8; n++) pq[i].push_back(8'(16 * i + n));
        drive();
        repeat (3) step();
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_write_en", 32'(fifo_write_en), 32'd0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                for (int n = 0; n < 4; n++) exp_q.push_back(8'(16 * i + 4 * r + n));
        drain = 1'b1;
        reset = 1'b1;
        wait_writes(32, 200, "t1_writes");
        repeat (3) step();
        if (log_d.size() >= 32) begin
            check("t1_first_id", 32'(log_id[0]), 32'd0);
            bad = 0;
            for (int k = 1; k < 32; k++) begin
                d = log_c[k] - log_c[k-1];
                expd = (k % 4 == 0) ? 2 : 1;
                if (d != expd) bad++;
            end
            check("t1_bubbles", 32'(bad), 32'd0);
            check("t1_span", 32'(log_c[31] - log_c[0] + 1), 32'd39);
        end
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        wait_fifo_empty(40);

        // Test 2: lone producer 2 with ten beats.
        clear_log();
        drain = 1'b0;
        for (int n = 0; n < 10; n++) begin
            pq[2].push_back(8'(8'hA0 + n));
            exp_q.push_back(8'(8'hA0 + n));
        end
        drive();
        wait_writes(10, 100, "t2_writes");
        repeat (3) step();
        if (log_d.size() >= 10) begin
            bad = 0;
            for (int k = 0; k < 10; k++) if (log_id[k] != 2) bad++;
            check("t2_ids", 32'(bad), 32'd0);
            check("t2_bubble_a", 32'(log_c[4] - log_c[3]), 32'd2);
            check("t2_bubble_b", 32'(log_c[8] - log_c[7]), 32'd2);
            check("t2_span", 32'(log_c[9] - log_c[0] + 1), 32'd12);
        end
        check("t2_fifo_count", 32'(fifo_q.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            v = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
            check("t2_readback", 32'(v), 32'(8'hA0 + k));
        end
        drive();
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Test 3: producer 1 drops valid after two beats while 3 waits.
        clear_log();
        drain = 1'b1;
        pq[1].push_back(8'h51);
        pq[1].push_back(8'h52);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h71);
        exp_q.push_back(8'h72);
        drive();
        step();
        pq[3].push_back(8'h71);
        pq[3].push_back(8'h72);
        drive();
        wait_writes(4, 50, "t3_writes");
        if (log_d.size() >= 4) begin
            check("t3_owner1_a", 32'(log_id[0]), 32'd1);
            check("t3_owner1_b", 32'(log_id[1]), 32'd1);
            check("t3_next_id", 32'(log_id[2]), 32'd3);
        end
        repeat (3) step();
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);
        wait_fifo_empty(20);

        // Test 4: fifo full while producer 0 owns the grant.
        clear_log();
        rd_log.delete();
        drain = 1'b0;
        for (int k = 0; k < 15; k++) fifo_q.push_back(8'hEE);
        for (int n = 0; n < 6; n++) begin
            pq[0].push_back(8'(8'hC0 + n));
            exp_q.push_back(8'(8'hC0 + n));
        end
        drive();
        wait_writes(1, 20, "t4_first");
        for (int k = 0; k < 8; k++) begin
            step();
            check("t4_hold_we", 32'(s_we), 32'd0);
            check("t4_hold_ready", 32'(s_rdy), 32'd0);
            check("t4_hold_grant", 32'(s_gv), 32'd1);
            check("t4_hold_id", 32'(s_gid), 32'd0);
        end
        for (int r = 2; r <= 4; r++) begin
            rd_once = 1'b1;
            step();
            wait_writes(r, 5, "t4_resume");
        end
        step();
        check("t4_release_after_4", 32'(s_gv), 32'd0);
        drain = 1'b1;
        wait_writes(6, 60, "t4_rest");
        wait_fifo_empty(40);
        bad = 0;
        for (int k = 0; k < 21; k++) begin
            expd = (k < 15) ? 8'hEE : 8'(8'hC0 + k - 15);
            if (k >= rd_log.size() || int'(rd_log[k]) != expd) bad++;
        end
        check("t4_read_count", 32'(rd_log.size()), 32'd21);
        check("t4_read_order", 32'(bad), 32'd0);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Test 5: reset mid-burst of producer 1.
        clear_log();
        for (int n = 0; n < 6; n++) begin
            pq[1].push_back(8'(8'h90 + n));
            exp_q.push_back(8'(8'h90 + n));
        end
        drive();
        wait_writes(2, 20, "t5_two_beats");
        check("t5_pre_write_en", 32'(fifo_write_en), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_rst_write_en", 32'(fifo_write_en), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        check("t5_rst_grant", 32'(grant_valid), 32'd0);
        check("t5_rst_id", 32'(grant_id), 32'd0);
        for (int i = 0; i < N; i++) pq[i].delete();
        exp_q.delete();
        drive();
        repeat (2) step();
        check("t5_no_accept", 32'(log_d.size()), 32'd2);
        reset = 1'b1;
        clear_log();
        pq[0].push_back(8'hB0);
        pq[1].push_back(8'hB1);
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hB1);
        drive();
        wait_writes(2, 20, "t5_after_reset");
        if (log_d.size() >= 2) begin
            check("t5_first_id", 32'(log_id[0]), 32'd0);
            check("t5_second_id", 32'(log_id[1]), 32'd1);
        end
        repeat (2) step();
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        wait_fifo_empty(20);

        // Test 6: random valid patterns, sparse reads, per-producer order.
        sb_en = 1'b0;
        drain = 1'b0;
        rand_mode = 1'b1;
        rd_log.delete();
        for (int i = 0; i < N; i++) begin
            exp_seq[i] = 0;
            gen_seq[i] = 0;
            pq[i].delete();
        end
        for (int c = 0; c < 512; c++) begin
            en = N'($urandom);
            for (int i = 0; i < N; i++) begin
                while (pq[i].size() < 2) begin
                    pq[i].push_back(8'((i << 6) | (gen_seq[i] % 64)));
                    gen_seq[i]++;
                end
            end
            drive();
            step();
        end
        en = '0;
        drive();
        step();
        drain = 1'b1;
        wait_fifo_empty(40);
        check("t6_reads_seen", 32'(rd_log.size() > 20), 32'd1);
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
